iss_fetch_queue: RTL and testbench
==================================

ISS_FETCH_QUEUE -- requirements
Module: iss_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC/instruction width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of two, minimum 2.
REQ-003 SHALL have parameter CNT_W, default $clog2(DEPTH)+1, occupancy counter width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port clr  in  1  synchronous flush (branch mispredict / redirect).
REQ-007 SHALL have port in_valid_i  in  1  fetch stage presents an entry.
REQ-008 SHALL have port in_ready_o  out  1  queue accepts an entry this cycle.
REQ-009 SHALL have ports next_pc_i, instr_i, curr_pc_i, next_pred_pc_i  in  XLEN each  fetch payload.
REQ-010 SHALL have port brn_pred_i  in  1  branch-predicted-taken flag.
REQ-011 SHALL have port out_valid_o  out  1  head entry valid to issue.
REQ-012 SHALL have port out_ready_i  in  1  issue stage consumes head.
REQ-013 SHALL have ports next_pc_o, instr_o, curr_pc_o, next_pred_pc_o  out  XLEN each, and brn_pred_o  out  1  head payload.
REQ-014 SHALL have ports count_o  out  CNT_W  occupancy; full_o, empty_o  out  1 each.

Function
REQ-015 SHALL store entries in a circular buffer of DEPTH slots, each {next_pc, instr, brn_pred, curr_pc, next_pred_pc}.
REQ-016 SHALL use write and read pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-017 SHALL push on a cycle where in_valid_i & in_ready_o & ~clr: write the slot at the write pointer, advance it.
REQ-018 SHALL pop on a cycle where out_valid_o & out_ready_i & ~clr: advance the read pointer.
REQ-019 SHALL drive in_ready_o = ~full_o, combinationally from registered state only; no pop-to-push pass-through when full.
REQ-020 SHALL drive out_valid_o = ~empty_o; payload outputs equal the slot at the read pointer (no combinational input-to-output path).
REQ-021 SHALL give 1-cycle latency: entry pushed at edge N is visible on out_* after edge N when queue was empty.
REQ-022 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers; legal at any non-full, non-empty occupancy.
REQ-023 SHALL, when empty, ignore out_ready_i; when full, ignore in_valid_i (entry not written, pointers unchanged).
REQ-024 SHALL update count_o by +1 on push only, -1 on pop only, 0 otherwise; range 0..DEPTH.
REQ-025 SHALL assert full_o iff count_o == DEPTH and empty_o iff count_o == 0.
REQ-026 SHALL, on clr, set both pointers and count to 0 at the next edge, discarding any same-cycle push and pop; clr has priority over all handshakes.
REQ-027 SHALL not clear slot contents on clr; only occupancy state is reset (out_valid_o = 0 masks stale payload).
REQ-028 SHALL preserve FIFO order: entries pop in exactly push order, no loss or duplication across pointer wrap.

Reset
REQ-029 SHALL, on reset_n low, immediately (asynchronously) clear pointers, count, and every slot to 0.
REQ-030 SHALL hold after reset: out_valid_o = 0, in_ready_o = 1, empty_o = 1, full_o = 0, count_o = 0, all payload outputs 0.
REQ-031 SHALL, on reset_n assertion mid-transfer, discard all entries; first push after reset_n rises is stored at slot 0.

Verification
REQ-032 SHALL test reset: reset_n low with in_valid_i = 1 -> count_o 0, out_valid_o 0, instr_o 0x00000000; release -> in_ready_o 1.
REQ-033 SHALL test fill/drain: DEPTH=4, out_ready_i = 0, push instr 0x11,0x22,0x33,0x44,0x55 -> full_o after 4th, 0x55 dropped; drain -> 0x11..0x44 in order, empty_o after 4 pops.
REQ-034 SHALL test wrap: 10 cycles continuous push+pop at count 2 -> count_o stays 2, order preserved across pointer wrap.
REQ-035 SHALL test flush: count 3, clr = 1 with in_valid_i = 1 and out_ready_i = 1 -> next cycle count_o 0, out_valid_o 0, pushed entry absent.
REQ-036 SHALL test latency: empty queue, push curr_pc 0x1000, brn_pred 1 -> next cycle out_valid_o 1, curr_pc_o 0x1000, brn_pred_o 1.
REQ-037 SHALL test parameters: XLEN=64, DEPTH=8 -> full_o at count_o 8, 64-bit payload intact.

Source files
------------

// File: rtl/iss_fetch_queue.sv
// iss_fetch_queue
//   Circular-buffer queue that sits between the fetch and issue stages. It has
//   DEPTH slots, and each slot holds {next_pc, instr, brn_pred, curr_pc,
//   next_pred_pc}. DEPTH must be a power of two and at least 2, so the
//   pointers wrap naturally.
//
//   Ports
//     clk, reset_n        single rising-edge clock, asynchronous active-low reset
//     clr                 synchronous flush (redirect); overrides both handshakes
//     in_valid_i/in_ready_o   push handshake; ready is simply ~full
//     next_pc_i, instr_i, curr_pc_i, next_pred_pc_i, brn_pred_i  push payload
//     out_valid_o/out_ready_i pop handshake; valid is simply ~empty
//     next_pc_o, instr_o, curr_pc_o, next_pred_pc_o, brn_pred_o  head payload
//     count_o, full_o, empty_o  occupancy status
module iss_fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] next_pc_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] curr_pc_i,
  input  logic [XLEN-1:0] next_pred_pc_i,
  input  logic            brn_pred_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] curr_pc_o,
  output logic [XLEN-1:0] next_pred_pc_o,
  output logic            brn_pred_o,
  output logic [CNT_W-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] instr;
    logic            brn_pred;
    logic [XLEN-1:0] curr_pc;
    logic [XLEN-1:0] next_pred_pc;
  } entry_t;

  entry_t           slot_q [DEPTH];
  entry_t           wr_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Status and handshakes depend only on registered occupancy. When the queue
  // is full, a same-cycle pop does not open a slot for a push.
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign push  = in_valid_i & ~full & ~clr;
  assign pop   = out_ready_i & ~empty & ~clr;

  assign wr_entry = '{next_pc:      next_pc_i,
                      instr:        instr_i,
                      brn_pred:     brn_pred_i,
                      curr_pc:      curr_pc_i,
                      next_pred_pc: next_pred_pc_i};

  // Slot storage. A flush leaves the contents in place; out_valid_o = 0 hides
  // the stale head until the slot is written again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else if (push) begin
      slot_q[wr_ptr] <= wr_entry;
    end
  end

  // Occupancy state: pointers and count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign head           = slot_q[rd_ptr];
  assign next_pc_o      = head.next_pc;
  assign instr_o        = head.instr;
  assign brn_pred_o     = head.brn_pred;
  assign curr_pc_o      = head.curr_pc;
  assign next_pred_pc_o = head.next_pred_pc;

  assign in_ready_o  = ~full;
  assign out_valid_o = ~empty;
  assign full_o      = full;
  assign empty_o     = empty;
  assign count_o     = count;

endmodule

// File: tb/tb_iss_fetch_queue.sv
// tb_iss_fetch_queue
//   Drives two queue instances with the same stimulus: a 32-bit/4-entry one
//   and a 64-bit/8-entry one. Each instance is compared against its own
//   queue-based reference model, plus directed expectations for the
//   reset, latency, fill/drain, wrap, flush and wide-payload scenarios.
module tb_iss_fetch_queue;

  typedef struct packed {
    logic [63:0] npc;
    logic [63:0] ins;
    logic [63:0] cpc;
    logic [63:0] nppc;
    logic        brn;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  ent_t cur = '0;

  logic        a_in_ready, a_out_valid, a_brn, a_full, a_empty;
  logic [31:0] a_npc, a_ins, a_cpc, a_nppc;
  logic [2:0]  a_count;
  logic        b_in_ready, b_out_valid, b_brn, b_full, b_empty;
  logic [63:0] b_npc, b_ins, b_cpc, b_nppc;
  logic [3:0]  b_count;

  int checks = 0;
  int errors = 0;
  bit in_rst = 1'b0;
  ent_t qa[$];
  ent_t qb[$];

  always #5 clk = ~clk;

  iss_fetch_queue #(.XLEN(32), .DEPTH(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .next_pc_i(cur.npc[31:0]), .instr_i(cur.ins[31:0]),
    .curr_pc_i(cur.cpc[31:0]), .next_pred_pc_i(cur.nppc[31:0]),
    .brn_pred_i(cur.brn),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready),
    .next_pc_o(a_npc), .instr_o(a_ins), .curr_pc_o(a_cpc),
    .next_pred_pc_o(a_nppc), .brn_pred_o(a_brn),
    .count_o(a_count), .full_o(a_full), .empty_o(a_empty)
  );

  iss_fetch_queue #(.XLEN(64), .DEPTH(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .next_pc_i(cur.npc), .instr_i(cur.ins),
    .curr_pc_i(cur.cpc), .next_pred_pc_i(cur.nppc),
    .brn_pred_i(cur.brn),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready),
    .next_pc_o(b_npc), .instr_o(b_ins), .curr_pc_o(b_cpc),
    .next_pred_pc_o(b_nppc), .brn_pred_o(b_brn),
    .count_o(b_count), .full_o(b_full), .empty_o(b_empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.npc  = {$urandom, $urandom};
    e.ins  = {$urandom, $urandom};
    e.cpc  = {$urandom, $urandom};
    e.nppc = {$urandom, $urandom};
    e.brn  = 1'($urandom);
    return e;
  endfunction

  // Reference behaviour for one clock edge: a flush empties the queue. Otherwise,
  // a pop takes the oldest entry and a push appends the new entry if the queue
  // was not full before the edge.
  task automatic model_edge();
    bit pa, pb, wa, wb;
    if (in_rst) return;
    if (clr) begin
      qa.delete();
      qb.delete();
      return;
    end
    pa = out_ready && qa.size() > 0;
    pb = out_ready && qb.size() > 0;
    wa = in_valid && qa.size() < 4;
    wb = in_valid && qb.size() < 8;
    if (pa) void'(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (wa) qa.push_back(cur);
    if (wb) qb.push_back(cur);
  endtask

  task automatic check_outs();
    chk("a_count", 64'(a_count), 64'(qa.size()));
    chk("a_full", 64'(a_full), 64'(qa.size() == 4));
    chk("a_empty", 64'(a_empty), 64'(qa.size() == 0));
    chk("a_out_valid", 64'(a_out_valid), 64'(qa.size() != 0));
    chk("a_in_ready", 64'(a_in_ready), 64'(qa.size() != 4));
    if (qa.size() > 0) begin
      chk("a_next_pc", 64'(a_npc), 64'(qa[0].npc[31:0]));
      chk("a_instr", 64'(a_ins), 64'(qa[0].ins[31:0]));
      chk("a_curr_pc", 64'(a_cpc), 64'(qa[0].cpc[31:0]));
      chk("a_next_pred_pc", 64'(a_nppc), 64'(qa[0].nppc[31:0]));
      chk("a_brn_pred", 64'(a_brn), 64'(qa[0].brn));
    end
    chk("b_count", 64'(b_count), 64'(qb.size()));
    chk("b_full", 64'(b_full), 64'(qb.size() == 8));
    chk("b_empty", 64'(b_empty), 64'(qb.size() == 0));
    chk("b_out_valid", 64'(b_out_valid), 64'(qb.size() != 0));
    chk("b_in_ready", 64'(b_in_ready), 64'(qb.size() != 8));
    if (qb.size() > 0) begin
      chk("b_next_pc", b_npc, qb[0].npc);
      chk("b_instr", b_ins, qb[0].ins);
      chk("b_curr_pc", b_cpc, qb[0].cpc);
      chk("b_next_pred_pc", b_nppc, qb[0].nppc);
      chk("b_brn_pred", 64'(b_brn), 64'(qb[0].brn));
    end
  endtask

  // One clock: the model sees the same pre-edge inputs as the DUTs; outputs
  // are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic enter_reset();
    reset_n = 1'b0;
    in_rst  = 1'b1;
    qa.delete();
    qb.delete();
    #1;
    chk("rst_a_count", 64'(a_count), 64'd0);
    chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_instr", 64'(a_ins), 64'd0);
    chk("rst_b_count", 64'(b_count), 64'd0);
    chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) cycle();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset with a push attempt held active.
    #1;
    in_valid = 1'b1;
    cur = rnd_ent();
    enter_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_a_count", 64'(a_count), 64'd0);
    chk("rst_hold_a_instr", 64'(a_ins), 64'd0);
    chk("rst_hold_a_curr_pc", 64'(a_cpc), 64'd0);
    chk("rst_hold_b_next_pc", b_npc, 64'd0);
    chk("rst_hold_b_brn", 64'(b_brn), 64'd0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    in_rst   = 1'b0;
    #1;
    chk("rst_rel_a_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_rel_a_empty", 64'(a_empty), 64'd1);
    chk("rst_rel_a_full", 64'(a_full), 64'd0);
    cycle();

    // One-cycle latency from an empty queue.
    cur = rnd_ent();
    cur.cpc = 64'h1000;
    cur.brn = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    cycle();
    chk("lat_a_valid", 64'(a_out_valid), 64'd1);
    chk("lat_a_curr_pc", 64'(a_cpc), 64'h1000);
    chk("lat_a_brn", 64'(a_brn), 64'd1);
    chk("lat_b_curr_pc", b_cpc, 64'h1000);
    drain(1);

    // Fill/drain: the fifth push overflows the 4-entry queue.
    for (int i = 1; i <= 5; i++) begin
      cur = rnd_ent();
      cur.ins = 64'(i * 'h11);
      in_valid = 1'b1;
      cycle();
      if (i == 4) chk("fill_a_full_at4", 64'(a_full), 64'd1);
    end
    chk("fill_a_count", 64'(a_count), 64'd4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_a_instr", 64'(a_ins), 64'(i * 'h11));
      cycle();
    end
    chk("drain_a_empty", 64'(a_empty), 64'd1);
    drain(4);

    // Wide instance fills to 8; ninth push rejected.
    for (int i = 0; i < 9; i++) begin
      cur = rnd_ent();
      in_valid = 1'b1;
      cycle();
    end
    chk("wide_b_full", 64'(b_full), 64'd1);
    chk("wide_b_count", 64'(b_count), 64'd8);
    drain(8);

    // Continuous push+pop at occupancy 2 across pointer wrap.
    for (int i = 0; i < 2; i++) begin
      cur = rnd_ent();
      in_valid = 1'b1;
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cur = rnd_ent();
      cycle();
      chk("wrap_a_count", 64'(a_count), 64'd2);
      chk("wrap_b_count", 64'(b_count), 64'd2);
    end
    drain(2);

    // Flush at count 3 with both handshakes active.
    for (int i = 0; i < 3; i++) begin
      cur = rnd_ent();
      in_valid = 1'b1;
      cycle();
    end
    clr = 1'b1;
    out_ready = 1'b1;
    cur = rnd_ent();
    cycle();
    chk("flush_a_count", 64'(a_count), 64'd0);
    chk("flush_a_valid", 64'(a_out_valid), 64'd0);
    clr = 1'b0;
    in_valid = 1'b0;
    cycle();
    chk("flush_a_absent", 64'(a_out_valid), 64'd0);

    // Asynchronous reset in the middle of traffic, then a fresh push.
    for (int i = 0; i < 2; i++) begin
      cur = rnd_ent();
      in_valid = 1'b1;
      out_ready = 1'b0;
      cycle();
    end
    #2;
    enter_reset();
    cycle();
    reset_n = 1'b1;
    in_rst  = 1'b0;
    cur = rnd_ent();
    in_valid = 1'b1;
    cycle();
    chk("post_rst_a_count", 64'(a_count), 64'd1);
    chk("post_rst_a_instr", 64'(a_ins), 64'(cur.ins[31:0]));
    drain(1);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cur = rnd_ent();
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 55);
      clr       = ($urandom_range(0, 99) < 4);
      cycle();
    end
    clr = 1'b0;
    drain(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
